// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, oversampling tick positions,
// receiver state encoding and the 2-of-3 majority vote helper.
package uart_pkg;

  localparam int DATA_BITS  = 8;
  localparam int OVERSAMPLE = 16;

  // The three mid-bit samples that are voted on
  localparam logic [3:0] SAMPLE_TICK_A = 4'd7;
  localparam logic [3:0] SAMPLE_TICK_B = 4'd8;
  localparam logic [3:0] SAMPLE_TICK_C = 4'd9;

  localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_e;

  // Two-out-of-three vote used to reject single-sample noise
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_x16.sv
// 8-N-1 receiver core: 2-FF input synchroniser, 16x oversampled framing FSM
// and 3-sample majority vote. Emits a one-mclk byte strobe on a good stop bit
// and a one-mclk framing error pulse on a bad one.
module uart_rx_x16
  import uart_pkg::*;
(
  input  logic       mclk,
  input  logic       reset,
  input  logic       baud_x16,
  input  logic       serial,
  output logic [7:0] rx_byte,
  output logic       byte_strobe,
  output logic       framing_error
);

  logic       sync1_r;
  logic       rx_s;
  logic       idle_ok_r;
  rx_state_e  state_r;
  rx_state_e  state_next_s;
  logic [3:0] tick_r;
  logic [2:0] idx_r;
  logic [7:0] shift_r;
  logic [1:0] samp_r;
  logic       maj_s;

  // The third sample is taken live on the tick that resolves the vote
  assign maj_s   = majority3(samp_r[0], samp_r[1], rx_s);
  assign rx_byte = shift_r;

  // Synchronise the asynchronous RX pin; resets low so a line stuck low after reset is not mistaken for idle
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      sync1_r <= 1'b0;
      rx_s    <= 1'b0;
    end else begin
      sync1_r <= serial;
      rx_s    <= sync1_r;
    end
  end

  // Remember that the line has been seen idle-high since reset before start edges are trusted
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      idle_ok_r <= 1'b0;
    end else if (rx_s) begin
      idle_ok_r <= 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; every transition is qualified by the 16x strobe
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (baud_x16 && idle_ok_r && !rx_s) state_next_s = START;
        else                                state_next_s = IDLE;
      end
      START: begin
        if (baud_x16 && tick_r == SAMPLE_TICK_C && maj_s) state_next_s = IDLE;
        else if (baud_x16 && tick_r == LAST_TICK)         state_next_s = DATA;
        else                                              state_next_s = START;
      end
      DATA: begin
        if (baud_x16 && tick_r == LAST_TICK && idx_r == LAST_BIT) state_next_s = STOP;
        else                                                      state_next_s = DATA;
      end
      STOP: begin
        if (baud_x16 && tick_r == SAMPLE_TICK_C) state_next_s = maj_s ? IDLE : BREAK;
        else                                     state_next_s = STOP;
      end
      BREAK: begin
        if (baud_x16 && rx_s) state_next_s = IDLE;
        else                  state_next_s = BREAK;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Stop-bit verdict outputs, valid only on the vote-resolving tick of STOP
  always_comb begin
    byte_strobe   = 1'b0;
    framing_error = 1'b0;
    if (baud_x16 && state_r == STOP && tick_r == SAMPLE_TICK_C) begin
      byte_strobe   = maj_s;
      framing_error = !maj_s;
    end else begin
      byte_strobe   = 1'b0;
      framing_error = 1'b0;
    end
  end

  // Tick counter, bit index, vote samples and LSB-first shift register advance on each 16x tick
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      tick_r  <= 4'd0;
      idx_r   <= 3'd0;
      shift_r <= 8'h00;
      samp_r  <= 2'b00;
    end else if (baud_x16) begin
      if (state_r == IDLE || state_r == BREAK) tick_r <= 4'd0;
      else                                     tick_r <= tick_r + 4'd1;
      if (tick_r == SAMPLE_TICK_A) samp_r[0] <= rx_s;
      if (tick_r == SAMPLE_TICK_B) samp_r[1] <= rx_s;
      if (state_r == DATA && tick_r == SAMPLE_TICK_C) shift_r <= {maj_s, shift_r[7:1]};
      if (state_r == START)                               idx_r <= 3'd0;
      else if (state_r == DATA && tick_r == LAST_TICK)    idx_r <= idx_r + 3'd1;
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with a show-ahead byte FIFO. Good bytes from the receiver
// core are pushed on the stop-bit strobe edge; the host pops with
// read_strobe. A push into a full FIFO is dropped and flagged as overrun
// unless a pop in the same cycle frees a slot.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int NUM = 32,
  parameter int AW  = $clog2(NUM)
) (
  input  logic          mclk,
  input  logic          reset,
  input  logic          baud_x16,
  input  logic          serial,
  output logic [7:0]    read_data,
  input  logic          read_strobe,
  output logic          data_available,
  output logic          full,
  output logic [AW:0]   count,
  output logic          framing_error,
  output logic          overrun
);

  localparam logic [AW:0]   ZERO_COUNT = (AW+1)'(0);
  localparam logic [AW:0]   ONE_COUNT  = (AW+1)'(1);
  localparam logic [AW:0]   FULL_COUNT = (AW+1)'(NUM);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);

  logic [7:0]    rx_byte_s;
  logic          byte_strobe_s;
  logic          fe_pulse_s;

  logic [7:0]    mem_r [NUM];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW-1:0] rd_next_ptr_s;
  logic [AW:0]   count_r;
  logic [AW:0]   count_next_s;
  logic [7:0]    read_data_r;
  logic [7:0]    head_next_s;
  logic          data_available_r;
  logic          full_r;
  logic          framing_error_r;
  logic          overrun_r;
  logic          pop_s;
  logic          push_s;
  logic          drop_s;

  uart_rx_x16 u_rx (
    .mclk          (mclk),
    .reset         (reset),
    .baud_x16      (baud_x16),
    .serial        (serial),
    .rx_byte       (rx_byte_s),
    .byte_strobe   (byte_strobe_s),
    .framing_error (fe_pulse_s)
  );

  assign read_data      = read_data_r;
  assign data_available = data_available_r;
  assign full           = full_r;
  assign count          = count_r;
  assign framing_error  = framing_error_r;
  assign overrun        = overrun_r;

  assign rd_next_ptr_s = rd_ptr_r + PTR_ONE;

  // Push/pop qualification; a pop on a full FIFO makes room for a simultaneous push
  always_comb begin
    pop_s  = read_strobe && (count_r != ZERO_COUNT);
    push_s = byte_strobe_s && ((count_r != FULL_COUNT) || pop_s);
    drop_s = byte_strobe_s && (count_r == FULL_COUNT) && !pop_s;
  end

  // Occupancy after this edge
  always_comb begin
    count_next_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + ONE_COUNT;
      2'b01:   count_next_s = count_r - ONE_COUNT;
      default: count_next_s = count_r;
    endcase
  end

  // Head byte after this edge, bypassing storage when the incoming byte becomes the head
  always_comb begin
    head_next_s = read_data_r;
    if (pop_s) begin
      if (count_r == ONE_COUNT && push_s) head_next_s = rx_byte_s;
      else                                head_next_s = mem_r[rd_next_ptr_s];
    end else if (count_r == ZERO_COUNT && push_s) begin
      head_next_s = rx_byte_s;
    end else begin
      head_next_s = read_data_r;
    end
  end

  // Byte storage
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM; i++) mem_r[i] <= 8'h00;
    end else if (push_s) begin
      mem_r[wr_ptr_r] <= rx_byte_s;
    end
  end

  // Pointers, occupancy, registered head and status flags
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      wr_ptr_r         <= '0;
      rd_ptr_r         <= '0;
      count_r          <= ZERO_COUNT;
      read_data_r      <= 8'h00;
      data_available_r <= 1'b0;
      full_r           <= 1'b0;
      framing_error_r  <= 1'b0;
      overrun_r        <= 1'b0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop_s)  rd_ptr_r <= rd_next_ptr_s;
      count_r          <= count_next_s;
      read_data_r      <= head_next_s;
      data_available_r <= (count_next_s != ZERO_COUNT);
      full_r           <= (count_next_s == FULL_COUNT);
      framing_error_r  <= fe_pulse_s;
      overrun_r        <= drop_s;
    end
  end

endmodule
